// File: rtl/element_stamp_controller.sv
// ---------------------------------------------------------------------------
// element_stamp_controller
//
// Purpose:
//   Runs the stamping stage that follows element entry. Walks element memory
//   from address 0 to element_count-1, decodes each element into its
//   nodal-matrix stamp entries and hands them one at a time to the matrix
//   accumulator over a valid/ready link. end_process rises once every element
//   has been stamped.
//
// Ports:
//   clk, program_reset           clock, synchronous active-high reset
//   start_process, element_count begin a pass; count latched at start
//   mem_addr, mem_rd             element memory read (data valid 1 cycle later)
//   mem_type/value/exponent/node_a/node_b   element memory read data
//   stamp_valid, stamp_ready     stamp handshake
//   stamp_rhs/row/col/value/exponent/neg    stamp payload
//   busy, type_error, end_process           status
//
// Build option:
//   ERROR_HALT_EN  when defined, an unsupported element type halts the pass in
//                  ERROR instead of being skipped.
//
// States:
//   state    | meaning
//   IDLE     | waiting for start_process
//   FETCH    | mem_rd pulse for the current index
//   MEM_WAIT | memory data valid; captured at the end of this cycle
//   DECODE   | build the stamp entry mask for the captured element
//   STAMP    | present pending entries one by one until all are accepted
//   NEXT     | advance index, decide FETCH or DONE
//   DONE     | pass complete, hold until reset
//   ERROR    | unsupported type seen (ERROR_HALT_EN only), hold until reset
// ---------------------------------------------------------------------------
module element_stamp_controller #(
  parameter int ADDR_W = 5,
  parameter int NODE_W = 3,
  parameter int VAL_W  = 16
) (
  input  logic              clk,
  input  logic              program_reset,
  input  logic              start_process,
  input  logic [ADDR_W-1:0] element_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [1:0]        mem_type,
  input  logic [VAL_W-1:0]  mem_value,
  input  logic [3:0]        mem_exponent,
  input  logic [NODE_W-1:0] mem_node_a,
  input  logic [NODE_W-1:0] mem_node_b,
  output logic              stamp_valid,
  input  logic              stamp_ready,
  output logic              stamp_rhs,
  output logic [NODE_W-1:0] stamp_row,
  output logic [NODE_W-1:0] stamp_col,
  output logic [VAL_W-1:0]  stamp_value,
  output logic [3:0]        stamp_exponent,
  output logic              stamp_neg,
  output logic              busy,
  output logic              type_error,
  output logic              end_process
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_DECODE   = 3'd3;
  localparam logic [2:0] S_STAMP    = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] count_q;
  logic [1:0]        el_type_q;
  logic [VAL_W-1:0]  el_value_q;
  logic [3:0]        el_exp_q;
  logic [NODE_W-1:0] node_a_q;
  logic [NODE_W-1:0] node_b_q;
  logic [3:0]        pend_q;
  logic              type_error_q;

  logic [ADDR_W-1:0] index_inc;
  assign index_inc = index_q + ADDR_W'(1);

  // Candidate stamp entries for the captured element. ent_ok marks the
  // entries that survive (no ground node, supported type, a!=b for R).
  logic [NODE_W-1:0]            a_m1, b_m1;
  logic                         a_nz, b_nz;
  logic [3:0]                   ent_ok;
  logic [3:0]                   ent_rhs;
  logic [3:0]                   ent_neg;
  logic [3:0][NODE_W-1:0]       ent_row;
  logic [3:0][NODE_W-1:0]       ent_col;

  assign a_m1 = node_a_q - NODE_W'(1);
  assign b_m1 = node_b_q - NODE_W'(1);
  assign a_nz = |node_a_q;
  assign b_nz = |node_b_q;

  always_comb begin
    ent_ok  = '0;
    ent_rhs = '0;
    ent_neg = '0;
    ent_row = '0;
    ent_col = '0;
    case (el_type_q)
      2'd0: begin
        if (node_a_q != node_b_q) begin
          ent_row[0] = a_m1;  ent_col[0] = a_m1;  ent_ok[0] = a_nz;
          ent_row[1] = b_m1;  ent_col[1] = b_m1;  ent_ok[1] = b_nz;
          ent_row[2] = a_m1;  ent_col[2] = b_m1;  ent_ok[2] = a_nz & b_nz;
          ent_neg[2] = 1'b1;
          ent_row[3] = b_m1;  ent_col[3] = a_m1;  ent_ok[3] = a_nz & b_nz;
          ent_neg[3] = 1'b1;
        end
      end
      2'd1: begin
        ent_rhs[0] = 1'b1;  ent_row[0] = a_m1;  ent_ok[0] = a_nz;
        ent_rhs[1] = 1'b1;  ent_row[1] = b_m1;  ent_ok[1] = b_nz;
        ent_neg[1] = 1'b1;
      end
      default: begin
        ent_ok = '0;
      end
    endcase
  end

  // The entry on the link is the lowest pending one; it stays selected until
  // its bit is cleared by a transfer, which keeps the payload stable.
  logic [1:0] sel;
  logic [3:0] pend_next;

  always_comb begin
    sel = 2'd3;
    if (pend_q[0])      sel = 2'd0;
    else if (pend_q[1]) sel = 2'd1;
    else if (pend_q[2]) sel = 2'd2;
  end

  assign pend_next = pend_q & ~(4'b0001 << sel);

  always_ff @(posedge clk) begin
    if (program_reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      count_q      <= '0;
      el_type_q    <= '0;
      el_value_q   <= '0;
      el_exp_q     <= '0;
      node_a_q     <= '0;
      node_b_q     <= '0;
      pend_q       <= '0;
      type_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_process) begin
            count_q <= element_count;
            index_q <= '0;
            state_q <= (element_count == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          el_type_q  <= mem_type;
          el_value_q <= mem_value;
          el_exp_q   <= mem_exponent;
          node_a_q   <= mem_node_a;
          node_b_q   <= mem_node_b;
          state_q    <= S_DECODE;
        end
        S_DECODE: begin
          if (el_type_q[1]) begin
            type_error_q <= 1'b1;
`ifdef ERROR_HALT_EN
            state_q      <= S_ERROR;
`else
            state_q      <= S_NEXT;
`endif
          end else if (ent_ok == 4'b0000) begin
            state_q <= S_NEXT;
          end else begin
            pend_q  <= ent_ok;
            state_q <= S_STAMP;
          end
        end
        S_STAMP: begin
          if (stamp_ready) begin
            pend_q <= pend_next;
            if (pend_next == 4'b0000) state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          index_q <= index_inc;
          state_q <= (index_inc == count_q) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
`ifdef ERROR_HALT_EN
        S_ERROR: begin
          state_q <= S_ERROR;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic in_stamp;
  assign in_stamp = (state_q == S_STAMP);

  assign mem_rd         = (state_q == S_FETCH);
  assign mem_addr       = mem_rd ? index_q : '0;
  assign stamp_valid    = in_stamp;
  assign stamp_rhs      = in_stamp & ent_rhs[sel];
  assign stamp_neg      = in_stamp & ent_neg[sel];
  assign stamp_row      = in_stamp ? ent_row[sel] : '0;
  // Column is forced to 0 for RHS entries; ent_col is already 0 there.
  assign stamp_col      = in_stamp ? ent_col[sel] : '0;
  assign stamp_value    = in_stamp ? el_value_q : '0;
  assign stamp_exponent = in_stamp ? el_exp_q : '0;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE) &&
                          (state_q != S_ERROR);
  assign type_error     = type_error_q;
  assign end_process    = (state_q == S_DONE);

endmodule

// File: tb/tb_element_stamp_controller.sv
module tb_element_stamp_controller;
  localparam int ADDR_W = 5;
  localparam int NODE_W = 3;
  localparam int VAL_W  = 16;

  logic              clk = 1'b0;
  logic              program_reset = 1'b1;
  logic              start_process = 1'b0;
  logic [ADDR_W-1:0] element_count = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [1:0]        mem_type = '0;
  logic [VAL_W-1:0]  mem_value = '0;
  logic [3:0]        mem_exponent = '0;
  logic [NODE_W-1:0] mem_node_a = '0;
  logic [NODE_W-1:0] mem_node_b = '0;
  logic              stamp_valid;
  logic              stamp_ready = 1'b0;
  logic              stamp_rhs;
  logic [NODE_W-1:0] stamp_row;
  logic [NODE_W-1:0] stamp_col;
  logic [VAL_W-1:0]  stamp_value;
  logic [3:0]        stamp_exponent;
  logic              stamp_neg;
  logic              busy;
  logic              type_error;
  logic              end_process;

  always #5 clk = ~clk;

  element_stamp_controller #(.ADDR_W(ADDR_W), .NODE_W(NODE_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .program_reset(program_reset), .start_process(start_process),
    .element_count(element_count), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_type(mem_type), .mem_value(mem_value), .mem_exponent(mem_exponent),
    .mem_node_a(mem_node_a), .mem_node_b(mem_node_b), .stamp_valid(stamp_valid),
    .stamp_ready(stamp_ready), .stamp_rhs(stamp_rhs), .stamp_row(stamp_row),
    .stamp_col(stamp_col), .stamp_value(stamp_value), .stamp_exponent(stamp_exponent),
    .stamp_neg(stamp_neg), .busy(busy), .type_error(type_error), .end_process(end_process)
  );

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] val;
    logic [3:0]  ex;
    logic [2:0]  a;
    logic [2:0]  b;
  } elem_t;

  typedef struct packed {
    logic        rhs;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        neg;
    logic [3:0]  ex;
    logic [15:0] val;
  } stamp_t;

  typedef struct {
    logic [1:0] typ;
    logic [2:0] a;
    logic [2:0] b;
    int         n;
    logic [7:0] first;   // {rhs, row, col, neg} of the first stamp
    logic       err;
  } vec_t;

  elem_t  mem [32];
  stamp_t got[$];
  stamp_t expq[$];
  int     addr_q[$];
  int     xfer_cyc[$];
  int     cyc = 0;
  int     stall_seen = 0;
  int     stall_left = 0;
  int     ready_mode = 0;   // 0 always, 1 random, 2 stall 2nd stamp, 3 never
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Link/memory agent: runs 2ns after each rising edge, so it sees settled
  // DUT outputs and its drives hold through the next edge.
  logic   rd_pend = 1'b0;
  int     rd_addr = 0;
  logic   prev_stall = 1'b0;
  stamp_t prev_payload;
  always @(posedge clk) begin
    stamp_t cur;
    logic   r;
    #2;
    cyc++;
    case (ready_mode)
      0: r = 1'b1;
      1: r = 1'($urandom);
      2: begin
        r = 1'b1;
        if (stamp_valid && got.size() == 1 && stall_left > 0) begin
          r = 1'b0;
          stall_left--;
        end
      end
      default: r = 1'b0;
    endcase
    stamp_ready = r;
    if (rd_pend) begin
      mem_type     = mem[rd_addr].typ;
      mem_value    = mem[rd_addr].val;
      mem_exponent = mem[rd_addr].ex;
      mem_node_a   = mem[rd_addr].a;
      mem_node_b   = mem[rd_addr].b;
    end else begin
      mem_type     = 2'($urandom);
      mem_value    = 16'($urandom);
      mem_exponent = 4'($urandom);
      mem_node_a   = 3'($urandom);
      mem_node_b   = 3'($urandom);
    end
    rd_pend = mem_rd;
    rd_addr = int'(mem_addr);
    if (mem_rd) addr_q.push_back(int'(mem_addr));
    cur = {stamp_rhs, stamp_row, stamp_col, stamp_neg, stamp_exponent, stamp_value};
    if (prev_stall && !program_reset) begin
      chk("hold_valid", 64'(stamp_valid), 64'd1);
      chk("hold_payload", 64'(cur), 64'(prev_payload));
    end
    if (stamp_valid && stamp_ready) begin
      got.push_back(cur);
      xfer_cyc.push_back(cyc);
    end
    if (stamp_valid && !stamp_ready) stall_seen++;
    prev_stall   = stamp_valid && !stamp_ready && !program_reset;
    prev_payload = cur;
  end

  function automatic logic [63:0] outs_vec();
    return 64'({mem_addr, mem_rd, stamp_valid, stamp_rhs, stamp_row, stamp_col,
                stamp_value, stamp_exponent, stamp_neg, busy, type_error, end_process});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    program_reset = 1'b1;
    start_process = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'd0);
    program_reset = 1'b0;
  endtask

  function automatic elem_t rand_elem(input bit allow_bad);
    elem_t e;
    int    r;
    r     = int'($urandom_range(0, 99));
    e.typ = (r < 45) ? 2'd0 : (r < 90 || !allow_bad) ? 2'd1 : 2'(2 + $urandom_range(0, 1));
    e.val = 16'($urandom);
    e.ex  = 4'($urandom);
    e.a   = 3'($urandom);
    e.b   = 3'($urandom);
    return e;
  endfunction

  // Reference: stamp list and read addresses straight from the element rules.
  task automatic run_pass(input int n);
    logic exp_err;
    logic exp_end;
    int   exp_reads;
    int   p[4];
    int   q[4];
    stamp_t s;
    bit   finished;
    got.delete(); expq.delete(); addr_q.delete(); xfer_cyc.delete();
    stall_seen = 0;
    exp_err = 1'b0;
    exp_end = 1'b1;
    exp_reads = 0;
    for (int i = 0; i < n; i++) begin
      elem_t e;
      e = mem[i];
      exp_reads = i + 1;
      s.ex = e.ex;
      s.val = e.val;
      if (e.typ == 2'd0) begin
        if (e.a != e.b) begin
          p[0] = e.a; q[0] = e.a;
          p[1] = e.b; q[1] = e.b;
          p[2] = e.a; q[2] = e.b;
          p[3] = e.b; q[3] = e.a;
          for (int k = 0; k < 4; k++) begin
            if (p[k] != 0 && q[k] != 0) begin
              s.rhs = 1'b0;
              s.row = 3'(p[k] - 1);
              s.col = 3'(q[k] - 1);
              s.neg = (k >= 2);
              expq.push_back(s);
            end
          end
        end
      end else if (e.typ == 2'd1) begin
        s.rhs = 1'b1;
        s.col = 3'd0;
        if (e.a != 0) begin s.row = 3'(e.a - 1); s.neg = 1'b0; expq.push_back(s); end
        if (e.b != 0) begin s.row = 3'(e.b - 1); s.neg = 1'b1; expq.push_back(s); end
      end else begin
        exp_err = 1'b1;
`ifdef ERROR_HALT_EN
        exp_end = 1'b0;
        break;
`endif
      end
    end
    element_count = ADDR_W'(n);
    start_process = 1'b1;
    @(negedge clk);
    element_count = ADDR_W'($urandom);   // must not affect a running pass
    finished = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (end_process || (type_error && !busy)) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pass_timeout", 64'(finished), 64'd1);
    repeat (3) @(negedge clk);   // start still high: DONE must ignore it
    chk("end_process", 64'(end_process), 64'(exp_end));
    chk("type_error", 64'(type_error), 64'(exp_err));
    chk("busy_after", 64'(busy), 64'd0);
    chk("stamp_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk("stamp_word", 64'(got[i]), 64'(expq[i]));
    chk("read_count", 64'(addr_q.size()), 64'(exp_reads));
    for (int i = 0; i < addr_q.size(); i++)
      chk("read_addr", 64'(addr_q[i]), 64'(i));
    start_process = 1'b0;
  endtask

  vec_t   tbl[10];
  stamp_t hand[4];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 3'd1, 3'd2, 4, 8'b0_000_000_0, 1'b0};
    tbl[1] = '{2'd0, 3'd0, 3'd2, 1, 8'b0_001_001_0, 1'b0};
    tbl[2] = '{2'd1, 3'd3, 3'd0, 1, 8'b1_010_000_0, 1'b0};
    tbl[3] = '{2'd0, 3'd2, 3'd2, 0, 8'b0,           1'b0};
    tbl[4] = '{2'd1, 3'd0, 3'd0, 0, 8'b0,           1'b0};
    tbl[5] = '{2'd2, 3'd1, 3'd2, 0, 8'b0,           1'b1};
    tbl[6] = '{2'd3, 3'd4, 3'd5, 0, 8'b0,           1'b1};
    tbl[7] = '{2'd1, 3'd1, 3'd4, 2, 8'b1_000_000_0, 1'b0};
    tbl[8] = '{2'd0, 3'd5, 3'd0, 1, 8'b0_100_100_0, 1'b0};
    tbl[9] = '{2'd0, 3'd7, 3'd6, 4, 8'b0_110_110_0, 1'b0};

    hand[0] = {1'b0, 3'd0, 3'd0, 1'b0, 4'd3, 16'd100};
    hand[1] = {1'b0, 3'd1, 3'd1, 1'b0, 4'd3, 16'd100};
    hand[2] = {1'b0, 3'd0, 3'd1, 1'b1, 4'd3, 16'd100};
    hand[3] = {1'b0, 3'd1, 3'd0, 1'b1, 4'd3, 16'd100};

    // Count 0: straight to DONE, no reads, no stamps.
    do_reset();
    got.delete(); addr_q.delete();
    element_count = '0;
    start_process = 1'b1;
    @(negedge clk);
    chk("zero_done_1cyc", 64'(end_process), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("zero_no_read", 64'(addr_q.size()), 64'd0);
    chk("zero_no_stamp", 64'(got.size()), 64'd0);
    chk("zero_still_done", 64'(end_process), 64'd1);
    start_process = 1'b0;

    // Single resistor 1-2, ready always high: four back-to-back stamps.
    ready_mode = 0;
    do_reset();
    mem[0] = '{2'd0, 16'd100, 4'd3, 3'd1, 3'd2};
    run_pass(1);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("r12_stamp", 64'(got[i]), 64'(hand[i]));
    if (xfer_cyc.size() == 4) chk("r12_back_to_back", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd3);
    else chk("r12_xfers", 64'(xfer_cyc.size()), 64'd4);

    // Single-element decode table.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      mem[0] = '{tbl[i].typ, 16'(200 + i), 4'(i), tbl[i].a, tbl[i].b};
      run_pass(1);
      chk("tbl_n", 64'(got.size()), 64'(tbl[i].n));
      chk("tbl_err", 64'(type_error), 64'(tbl[i].err));
      if (tbl[i].n > 0 && got.size() > 0) begin
        chk("tbl_first", 64'({got[0].rhs, got[0].row, got[0].col, got[0].neg}), 64'(tbl[i].first));
        chk("tbl_value", 64'({got[0].ex, got[0].val}), 64'({4'(i), 16'(200 + i)}));
      end
    end

    // Ready low for 5 cycles on the 2nd stamp.
    do_reset();
    ready_mode = 2;
    stall_left = 5;
    mem[0] = '{2'd0, 16'h1234, 4'd9, 3'd3, 3'd5};
    run_pass(1);
    chk("stall_cycles", 64'(stall_seen), 64'd5);
    ready_mode = 0;

    // Unsupported type in the middle of three elements.
    do_reset();
    mem[0] = '{2'd0, 16'd7, 4'd1, 3'd1, 3'd2};
    mem[1] = '{2'd2, 16'd8, 4'd2, 3'd1, 3'd3};
    mem[2] = '{2'd1, 16'd9, 4'd3, 3'd3, 3'd0};
    run_pass(3);

    // Reset while a stamp is waiting, then a fresh pass from address 0.
    do_reset();
    ready_mode = 3;
    mem[0] = '{2'd0, 16'd55, 4'd4, 3'd1, 3'd2};
    mem[1] = '{2'd1, 16'd66, 4'd5, 3'd2, 3'd6};
    element_count = 5'd2;
    start_process = 1'b1;
    for (int k = 0; k < 20 && !stamp_valid; k++) @(negedge clk);
    chk("mid_reach_stamp", 64'(stamp_valid), 64'd1);
    start_process = 1'b0;
    program_reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", outs_vec(), 64'd0);
    program_reset = 1'b0;
    ready_mode = 0;
    run_pass(2);

    // Randomized passes with random back-pressure.
    ready_mode = 1;
    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) mem[i] = rand_elem(1'b1);
      do_reset();
      run_pass(n);
    end

    // Maximum count: last read address is 30.
    for (int i = 0; i < 31; i++) mem[i] = rand_elem(1'b0);
    do_reset();
    run_pass(31);
    if (addr_q.size() > 0) chk("max_last_addr", 64'(addr_q[addr_q.size() - 1]), 64'd30);
    else chk("max_reads", 64'(addr_q.size()), 64'd31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
